// File: rtl/slow_to_fast_multi.sv
// Multi-channel slow-to-fast capture: synchronises a slow strobe into CLK, captures
// CHANNELS words on the selected strobe edge and presents them with valid/ready plus status.
module slow_to_fast_multi #(
  parameter int WIDTH       = 12,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                      CLK,
  input  logic                      CLR_N,
  input  logic                      slow_clk,
  input  logic [WIDTH*CHANNELS-1:0] async_data,
  input  logic [1:0]                edge_mode,
  input  logic                      data_ready,
  input  logic                      clr_status,
  output logic [WIDTH*CHANNELS-1:0] sync_data,
  output logic                      data_valid,
  output logic                      overrun,
  output logic                      stale,
  output logic [CNT_W-1:0]          edge_count
);

  localparam int BUS_W = WIDTH * CHANNELS;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  localparam logic [1:0] MODE_RISE = 2'd0;
  localparam logic [1:0] MODE_FALL = 2'd1;
  localparam logic [1:0] MODE_BOTH = 2'd2;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p0;
  logic                   prev_p1;
  logic                   rise;
  logic                   fall;
  logic                   trig;
  logic                   overrun_set;
  logic                   consume;
  logic [WD_W-1:0]        wd_cnt;
  logic [WD_W-1:0]        wd_next;

  function automatic logic trig_select(input logic [1:0] mode,
                                       input logic       r,
                                       input logic       f);
    logic t;
    t = 1'b0;
    case (mode)
      MODE_RISE: t = r;
      MODE_FALL: t = f;
      MODE_BOTH: t = r | f;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [WD_W-1:0] wd_step(input logic [WD_W-1:0] cnt,
                                             input logic            seen_edge);
    logic [WD_W-1:0] n;
    if (seen_edge)
      n = '0;
    else if (cnt >= WD_MAX)
      n = WD_MAX;
    else
      n = cnt + WD_W'(1);
    return n;
  endfunction

  // Stage 0: synchroniser chain on the slow strobe
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)
      sync_p0 <= '0;
    else if (SYNC_STAGES > 1)
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], slow_clk};
    else
      sync_p0 <= {SYNC_STAGES{slow_clk}};
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage 1: previous value and edge detection
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)
      prev_p1 <= 1'b0;
    else
      prev_p1 <= s_p0;
  end

  assign rise        = s_p0 & ~prev_p1;
  assign fall        = ~s_p0 & prev_p1;
  assign trig        = trig_select(edge_mode, rise, fall);
  assign consume     = data_valid & data_ready;
  assign overrun_set = trig & data_valid & ~data_ready;
  assign wd_next     = wd_step(wd_cnt, rise | fall);

  // Stage 2: capture register, handshake and status
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync_data  <= '0;
      data_valid <= 1'b0;
      edge_count <= '0;
    end else if (trig) begin
      sync_data  <= async_data;
      data_valid <= 1'b1;
      edge_count <= edge_count + CNT_W'(1);
    end else if (consume) begin
      data_valid <= 1'b0;
    end
  end

  // A new overrun in the same cycle as a clear keeps the flag set
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)
      overrun <= 1'b0;
    else if (overrun_set)
      overrun <= 1'b1;
    else if (clr_status)
      overrun <= 1'b0;
  end

  // The watchdog tracks raw strobe activity regardless of the capture mode
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      wd_cnt <= '0;
      stale  <= 1'b0;
    end else begin
      wd_cnt <= wd_next;
      stale  <= (wd_next == WD_MAX);
    end
  end

endmodule

// File: tb/tb_slow_to_fast_multi.sv
// Self-checking bench for slow_to_fast_multi: directed steps with random data, checked
// each cycle against a transaction-level model plus directed expectations.
module tb_slow_to_fast_multi;

  localparam int WIDTH       = 12;
  localparam int CHANNELS    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 1024;
  localparam int CNT_W       = 16;
  localparam int CNT_W_S     = 4;
  localparam int BUS_W       = WIDTH * CHANNELS;

  logic             CLK        = 1'b0;
  logic             CLR_N      = 1'b0;
  logic             slow_clk   = 1'b0;
  logic [BUS_W-1:0] async_data = '0;
  logic [1:0]       edge_mode  = 2'd0;
  logic             data_ready = 1'b0;
  logic             clr_status = 1'b0;

  logic [BUS_W-1:0]   sync_data,  sync_data_s;
  logic               data_valid, data_valid_s;
  logic               overrun,    overrun_s;
  logic               stale,      stale_s;
  logic [CNT_W-1:0]   edge_count;
  logic [CNT_W_S-1:0] edge_count_s;

  slow_to_fast_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SYNC_STAGES(SYNC_STAGES),
                       .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .slow_clk(slow_clk), .async_data(async_data),
    .edge_mode(edge_mode), .data_ready(data_ready), .clr_status(clr_status),
    .sync_data(sync_data), .data_valid(data_valid), .overrun(overrun),
    .stale(stale), .edge_count(edge_count));

  slow_to_fast_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SYNC_STAGES(SYNC_STAGES),
                       .TIMEOUT(TIMEOUT), .CNT_W(CNT_W_S)) dut_s (
    .CLK(CLK), .CLR_N(CLR_N), .slow_clk(slow_clk), .async_data(async_data),
    .edge_mode(edge_mode), .data_ready(data_ready), .clr_status(clr_status),
    .sync_data(sync_data_s), .data_valid(data_valid_s), .overrun(overrun_s),
    .stale(stale_s), .edge_count(edge_count_s));

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: strobe samples seen at each CLK edge; a strobe change becomes a
  // detected edge SYNC_STAGES+1 edges after it was first sampled.
  bit               hist[$];
  int               m_idle;
  bit               m_stale, m_valid, m_ovr;
  logic [BUS_W-1:0] m_data;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_reset();
    hist.delete();
    repeat (SYNC_STAGES + 1) hist.push_back(1'b0);
    m_idle  = 0;
    m_stale = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = '0;
    m_cnt   = '0;
  endtask

  task automatic model_step();
    bit was, now, ev_r, ev_f, fire;
    if (!CLR_N) begin
      model_reset();
      return;
    end
    was  = hist[0];
    now  = hist[1];
    ev_r = now && !was;
    ev_f = !now && was;
    case (edge_mode)
      2'd0:    fire = ev_r;
      2'd1:    fire = ev_f;
      2'd2:    fire = ev_r || ev_f;
      default: fire = 1'b0;
    endcase
    if (ev_r || ev_f) m_idle = 0;
    else if (m_idle < TIMEOUT) m_idle++;
    m_stale = (m_idle == TIMEOUT);
    if (fire && m_valid && !data_ready) m_ovr = 1'b1;
    else if (clr_status) m_ovr = 1'b0;
    if (fire) begin
      m_data  = async_data;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 1'b1;
    end else if (m_valid && data_ready) begin
      m_valid = 1'b0;
    end
    hist.push_back(slow_clk);
    void'(hist.pop_front());
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_model();
    check("model.sync_data",    64'(sync_data),    64'(m_data));
    check("model.data_valid",   64'(data_valid),   64'(m_valid));
    check("model.overrun",      64'(overrun),      64'(m_ovr));
    check("model.stale",        64'(stale),        64'(m_stale));
    check("model.edge_count",   64'(edge_count),   64'(m_cnt));
    check("model_s.sync_data",  64'(sync_data_s),  64'(m_data));
    check("model_s.data_valid", 64'(data_valid_s), 64'(m_valid));
    check("model_s.overrun",    64'(overrun_s),    64'(m_ovr));
    check("model_s.stale",      64'(stale_s),      64'(m_stale));
    check("model_s.edge_count", 64'(edge_count_s), 64'(m_cnt[CNT_W_S-1:0]));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      check_model();
    end
  endtask

  function automatic logic [BUS_W-1:0] rand_word();
    return BUS_W'({$urandom(), $urandom()});
  endfunction

  logic [BUS_W-1:0] word_a, word_b;
  logic [CNT_W-1:0] base;
  int               deltas [4] = '{8, 8, 16, 0};

  initial begin
    model_reset();

    // Reset then idle: everything zero, stale after exactly TIMEOUT cycles
    tick(3);
    check("reset.data_valid", 64'(data_valid), 64'(0));
    check("reset.sync_data",  64'(sync_data),  64'(0));
    check("reset.edge_count", 64'(edge_count), 64'(0));
    check("reset.stale",      64'(stale),      64'(0));
    CLR_N = 1'b1;
    tick(TIMEOUT - 1);
    check("idle.stale_before", 64'(stale), 64'(0));
    tick(1);
    check("idle.stale_at_timeout", 64'(stale), 64'(1));

    // Single rising edge
    async_data = 48'h123456789ABC;
    slow_clk   = 1'b1;
    tick(2);
    check("rise.valid_early", 64'(data_valid), 64'(0));
    tick(1);
    check("rise.valid",      64'(data_valid), 64'(1));
    check("rise.sync_data",  64'(sync_data),  64'(48'h123456789ABC));
    check("rise.edge_count", 64'(edge_count), 64'(1));
    check("rise.stale",      64'(stale),      64'(0));

    // Handshake and overrun
    data_ready = 1'b1; tick(1); data_ready = 1'b0;
    check("hs.consume", 64'(data_valid), 64'(0));
    slow_clk = 1'b0; tick(6);
    word_a = rand_word(); async_data = word_a; slow_clk = 1'b1; tick(6);
    slow_clk = 1'b0; tick(6);
    word_b = rand_word(); async_data = word_b; slow_clk = 1'b1; tick(6);
    check("hs.data_b",  64'(sync_data),  64'(word_b));
    check("hs.overrun", 64'(overrun),    64'(1));
    check("hs.valid",   64'(data_valid), 64'(1));
    data_ready = 1'b1; tick(1); data_ready = 1'b0;
    check("hs.drop_valid",   64'(data_valid), 64'(0));
    check("hs.overrun_held", 64'(overrun),    64'(1));
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
    check("hs.overrun_clr", 64'(overrun), 64'(0));
    slow_clk = 1'b0; tick(6);

    // Capture coincides with acceptance of a pending word
    word_a = rand_word(); async_data = word_a; slow_clk = 1'b1; tick(6);
    slow_clk = 1'b0; tick(6);
    word_b = rand_word(); async_data = word_b; slow_clk = 1'b1; tick(2);
    data_ready = 1'b1; tick(1); data_ready = 1'b0;
    check("sim.valid",   64'(data_valid), 64'(1));
    check("sim.data",    64'(sync_data),  64'(word_b));
    check("sim.overrun", 64'(overrun),    64'(0));
    data_ready = 1'b1; tick(1); data_ready = 1'b0;
    slow_clk = 1'b0; tick(6);

    // Mode sweep: 8 periods of 100 cycles per mode
    for (int m = 0; m < 4; m++) begin
      edge_mode = 2'(m);
      tick(2);
      base = m_cnt;
      for (int p = 0; p < 8; p++) begin
        async_data = rand_word();
        data_ready = 1'($urandom_range(0, 1));
        slow_clk   = 1'b1; tick(50);
        slow_clk   = 1'b0; tick(50);
      end
      data_ready = 1'b0;
      tick(5);
      check($sformatf("sweep.count_mode%0d", m), 64'(edge_count), 64'(base + CNT_W'(deltas[m])));
      check($sformatf("sweep.stale_mode%0d", m), 64'(stale), 64'(0));
    end

    // Bring the narrow counter to all-ones with a pending word, then reset mid-cycle
    edge_mode = 2'd2;
    for (int i = 0; i < 16; i++) begin
      if (m_cnt[CNT_W_S-1:0] == 4'hF) break;
      async_data = rand_word(); slow_clk = ~slow_clk; tick(4);
    end
    tick(2);
    check("pre_reset.count_s", 64'(edge_count_s), 64'(4'hF));
    check("pre_reset.valid",   64'(data_valid),   64'(1));
    @(posedge CLK);
    model_step();
    #3;
    CLR_N    = 1'b0;
    slow_clk = 1'b0;
    model_reset();
    #1;
    check("areset.valid",   64'(data_valid),   64'(0));
    check("areset.data",    64'(sync_data),    64'(0));
    check("areset.count",   64'(edge_count),   64'(0));
    check("areset.count_s", 64'(edge_count_s), 64'(0));
    check("areset.overrun", 64'(overrun),      64'(0));
    @(negedge CLK);
    tick(2);
    CLR_N = 1'b1;
    tick(3);
    check("post_reset.count", 64'(edge_count), 64'(0));

    // Wrap of the narrow counter
    for (int i = 0; i < 15; i++) begin
      async_data = rand_word(); slow_clk = ~slow_clk; tick(4);
    end
    tick(2);
    check("wrap.count_s_full", 64'(edge_count_s), 64'(4'hF));
    async_data = rand_word(); slow_clk = ~slow_clk; tick(6);
    check("wrap.count_s_zero", 64'(edge_count_s), 64'(0));
    check("wrap.count_wide",   64'(edge_count),   64'(16));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
